// File: rtl/mem_write_checker.sv
// Self-check monitor for the mips_mem write bus: compares bus writes in order against a
// loadable table of expected writes and produces a sticky pass/fail/timeout verdict.
module mem_write_checker #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned IDXBITS     = 2,
  parameter int unsigned CNTBITS     = 16,
  parameter int unsigned TIMEOUT     = 3000,
  parameter bit          STOP_ON_ERR = 1'b1
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_exp_we,
  input  logic [IDXBITS-1:0] i_exp_idx,
  input  logic [WIDTH-1:0]   i_exp_adr,
  input  logic [WIDTH-1:0]   i_exp_data,
  input  logic [IDXBITS:0]   i_num_exp,
  input  logic               i_start,
  input  logic               i_memwrite,
  input  logic [WIDTH-1:0]   i_adr,
  input  logic [WIDTH-1:0]   i_writedata,
  output logic               o_busy,
  output logic               o_pass,
  output logic               o_fail,
  output logic               o_timeout,
  output logic [CNTBITS-1:0] o_match_cnt,
  output logic [CNTBITS-1:0] o_err_cnt,
  output logic [WIDTH-1:0]   o_err_adr,
  output logic [WIDTH-1:0]   o_err_data
);

  localparam int unsigned PTRW = IDXBITS + 1;

  typedef enum logic [2:0] {StIdle, StRun, StPass, StFail, StTout} state_e;

  state_e             r_state, w_state_nxt;
  logic [WIDTH-1:0]   r_tbl_adr  [DEPTH];
  logic [WIDTH-1:0]   r_tbl_data [DEPTH];
  logic [PTRW-1:0]    r_ptr, w_ptr_nxt;
  logic [PTRW-1:0]    r_num, w_num_nxt;
  logic [CNTBITS-1:0] r_cyc, w_cyc_nxt;
  logic [CNTBITS-1:0] r_match_cnt, w_match_cnt_nxt;
  logic [CNTBITS-1:0] r_err_cnt, w_err_cnt_nxt;
  logic [WIDTH-1:0]   r_err_adr, w_err_adr_nxt;
  logic [WIDTH-1:0]   r_err_data, w_err_data_nxt;
  logic               r_first_err, w_first_err_nxt;

  logic [IDXBITS-1:0] w_idx;
  logic               w_hit;
  logic [PTRW-1:0]    w_num_lat;

  function automatic logic [CNTBITS-1:0] sat_inc(input logic [CNTBITS-1:0] v);
    return (v == '1) ? v : v + CNTBITS'(1);
  endfunction

  // ptr never reaches DEPTH while in RUN, so the low bits index the table directly.
  assign w_idx = r_ptr[IDXBITS-1:0];
  assign w_hit = (i_adr == r_tbl_adr[w_idx]) && (i_writedata == r_tbl_data[w_idx]);

  always_comb begin
    w_num_lat = i_num_exp;
    if (i_num_exp == '0) begin
      w_num_lat = PTRW'(1);
    end else if (i_num_exp > PTRW'(DEPTH)) begin
      w_num_lat = PTRW'(DEPTH);
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_ptr_nxt       = r_ptr;
    w_num_nxt       = r_num;
    w_cyc_nxt       = r_cyc;
    w_match_cnt_nxt = r_match_cnt;
    w_err_cnt_nxt   = r_err_cnt;
    w_err_adr_nxt   = r_err_adr;
    w_err_data_nxt  = r_err_data;
    w_first_err_nxt = r_first_err;

    if (i_start) begin
      w_state_nxt     = StRun;
      w_ptr_nxt       = '0;
      w_num_nxt       = w_num_lat;
      w_cyc_nxt       = '0;
      w_match_cnt_nxt = '0;
      w_err_cnt_nxt   = '0;
      w_err_adr_nxt   = '0;
      w_err_data_nxt  = '0;
      w_first_err_nxt = 1'b0;
    end else begin
      unique case (r_state)
        StRun: begin
          w_cyc_nxt = sat_inc(r_cyc);
          if (i_memwrite) begin
            if (w_hit) begin
              w_match_cnt_nxt = sat_inc(r_match_cnt);
              w_ptr_nxt       = r_ptr + PTRW'(1);
            end else begin
              w_err_cnt_nxt = sat_inc(r_err_cnt);
              if (!r_first_err) begin
                w_err_adr_nxt   = i_adr;
                w_err_data_nxt  = i_writedata;
                w_first_err_nxt = 1'b1;
              end
              if (!STOP_ON_ERR) begin
                w_ptr_nxt = r_ptr + PTRW'(1);
              end
            end
          end
          // Completion outranks a stop-on-error mismatch, which outranks the watchdog.
          if (w_ptr_nxt == r_num) begin
            w_state_nxt = (w_err_cnt_nxt == '0) ? StPass : StFail;
          end else if (i_memwrite && !w_hit && STOP_ON_ERR) begin
            w_state_nxt = StFail;
          end else if (r_cyc >= CNTBITS'(TIMEOUT - 1)) begin
            w_state_nxt = StTout;
          end
        end
        StPass: begin
          if (i_memwrite) begin
            w_err_cnt_nxt = sat_inc(r_err_cnt);
            if (!r_first_err) begin
              w_err_adr_nxt   = i_adr;
              w_err_data_nxt  = i_writedata;
              w_first_err_nxt = 1'b1;
            end
            w_state_nxt = StFail;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state     <= StIdle;
      r_ptr       <= '0;
      r_num       <= '0;
      r_cyc       <= '0;
      r_match_cnt <= '0;
      r_err_cnt   <= '0;
      r_err_adr   <= '0;
      r_err_data  <= '0;
      r_first_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_num       <= w_num_nxt;
      r_cyc       <= w_cyc_nxt;
      r_match_cnt <= w_match_cnt_nxt;
      r_err_cnt   <= w_err_cnt_nxt;
      r_err_adr   <= w_err_adr_nxt;
      r_err_data  <= w_err_data_nxt;
      r_first_err <= w_first_err_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_tbl_adr[i]  <= '0;
        r_tbl_data[i] <= '0;
      end
    end else if (i_exp_we && (r_state != StRun) && (32'(i_exp_idx) < DEPTH)) begin
      r_tbl_adr[i_exp_idx]  <= i_exp_adr;
      r_tbl_data[i_exp_idx] <= i_exp_data;
    end
  end

  assign o_busy      = (r_state == StRun);
  assign o_pass      = (r_state == StPass);
  assign o_fail      = (r_state == StFail);
  assign o_timeout   = (r_state == StTout);
  assign o_match_cnt = r_match_cnt;
  assign o_err_cnt   = r_err_cnt;
  assign o_err_adr   = r_err_adr;
  assign o_err_data  = r_err_data;

endmodule

// File: tb/tb_mem_write_checker.sv
// Directed bench: one stop-on-error and one keep-checking checker watch the same bus.
module tb_mem_write_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       exp_we = 1'b0;
  logic [1:0] exp_idx = '0;
  logic [7:0] exp_adr = '0;
  logic [7:0] exp_data = '0;
  logic [2:0] num_exp = '0;
  logic       start = 1'b0;
  logic       memwrite = 1'b0;
  logic [7:0] adr = '0;
  logic [7:0] writedata = '0;

  logic        s_busy, s_pass, s_fail, s_tout;
  logic [15:0] s_match, s_err;
  logic [7:0]  s_eadr, s_edata;
  logic        c_busy, c_pass, c_fail, c_tout;
  logic [15:0] c_match, c_err;
  logic [7:0]  c_eadr, c_edata;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mem_write_checker #(.TIMEOUT(300), .STOP_ON_ERR(1'b1)) u_stop (
    .i_clk(clk), .i_reset(reset), .i_exp_we(exp_we), .i_exp_idx(exp_idx),
    .i_exp_adr(exp_adr), .i_exp_data(exp_data), .i_num_exp(num_exp), .i_start(start),
    .i_memwrite(memwrite), .i_adr(adr), .i_writedata(writedata),
    .o_busy(s_busy), .o_pass(s_pass), .o_fail(s_fail), .o_timeout(s_tout),
    .o_match_cnt(s_match), .o_err_cnt(s_err), .o_err_adr(s_eadr), .o_err_data(s_edata)
  );

  mem_write_checker #(.TIMEOUT(300), .STOP_ON_ERR(1'b0)) u_cont (
    .i_clk(clk), .i_reset(reset), .i_exp_we(exp_we), .i_exp_idx(exp_idx),
    .i_exp_adr(exp_adr), .i_exp_data(exp_data), .i_num_exp(num_exp), .i_start(start),
    .i_memwrite(memwrite), .i_adr(adr), .i_writedata(writedata),
    .o_busy(c_busy), .o_pass(c_pass), .o_fail(c_fail), .o_timeout(c_tout),
    .o_match_cnt(c_match), .o_err_cnt(c_err), .o_err_adr(c_eadr), .o_err_data(c_edata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [1:0] i, input logic [7:0] a, input logic [7:0] d);
    exp_we = 1'b1; exp_idx = i; exp_adr = a; exp_data = d;
    tick();
    exp_we = 1'b0;
  endtask

  task automatic go(input logic [2:0] n);
    num_exp = n; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    memwrite = 1'b1; adr = a; writedata = d;
    tick();
    memwrite = 1'b0;
  endtask

  task automatic flags_s(input string tag, input logic [3:0] exp_bpft);
    chk(tag, 32'({s_busy, s_pass, s_fail, s_tout}), 32'(exp_bpft));
  endtask

  task automatic flags_c(input string tag, input logic [3:0] exp_bpft);
    chk(tag, 32'({c_busy, c_pass, c_fail, c_tout}), 32'(exp_bpft));
  endtask

  initial begin
    // Reset state
    tick(); tick();
    flags_s("rst_flags_s", 4'b0000);
    flags_c("rst_flags_c", 4'b0000);
    chk("rst_match", 32'(s_match), 0);
    chk("rst_err", 32'(s_err), 0);
    chk("rst_eadr", 32'(s_eadr), 0);
    chk("rst_edata", 32'(s_edata), 0);
    reset = 1'b1;
    tick();

    // Fibonacci baseline
    load(2'd0, 8'hFF, 8'h0D);
    go(3'd1);
    flags_s("base_busy", 4'b1000);
    repeat (39) tick();
    flags_s("base_still_busy", 4'b1000);
    wr(8'hFF, 8'h0D);
    flags_s("base_pass", 4'b0100);
    flags_c("base_pass_c", 4'b0100);
    chk("base_match", 32'(s_match), 1);
    chk("base_err", 32'(s_err), 0);

    // Single mismatch
    go(3'd1);
    wr(8'hFF, 8'h0C);
    flags_s("mm_fail", 4'b0010);
    chk("mm_err", 32'(s_err), 1);
    chk("mm_eadr", 32'(s_eadr), 'hFF);
    chk("mm_edata", 32'(s_edata), 'h0C);
    flags_c("mm_fail_c", 4'b0010);
    wr(8'hFF, 8'h0D);
    wr(8'h12, 8'h34);
    chk("mm_frozen_err", 32'(s_err), 1);
    chk("mm_frozen_match", 32'(s_match), 0);
    chk("mm_frozen_err_c", 32'(c_err), 1);
    flags_s("mm_still_fail", 4'b0010);

    // Ordered multi-entry, back-to-back
    load(2'd0, 8'h10, 8'h01);
    load(2'd1, 8'h11, 8'h01);
    load(2'd2, 8'h12, 8'h02);
    load(2'd3, 8'h13, 8'h03);
    go(3'd4);
    memwrite = 1'b1; adr = 8'h10; writedata = 8'h01; tick();
    chk("multi_w1_match_c", 32'(c_match), 1);
    adr = 8'h11; writedata = 8'h07; tick();
    flags_s("multi_stop_fail", 4'b0010);
    flags_c("multi_cont_busy", 4'b1000);
    adr = 8'h12; writedata = 8'h02; tick();
    flags_c("multi_cont_busy3", 4'b1000);
    adr = 8'h13; writedata = 8'h03; tick();
    memwrite = 1'b0;
    flags_c("multi_cont_fail", 4'b0010);
    chk("multi_match_c", 32'(c_match), 3);
    chk("multi_err_c", 32'(c_err), 1);
    chk("multi_eadr_c", 32'(c_eadr), 'h11);
    chk("multi_edata_c", 32'(c_edata), 'h07);
    chk("multi_match_s", 32'(s_match), 1);
    chk("multi_err_s", 32'(s_err), 1);

    // Timeout, no writes
    go(3'd4);
    repeat (299) tick();
    flags_s("tout_not_yet", 4'b1000);
    tick();
    flags_s("tout_hit", 4'b0001);
    flags_c("tout_hit_c", 4'b0001);

    // Final matching write on the timeout cycle
    go(3'd1);
    repeat (299) tick();
    wr(8'h10, 8'h01);
    flags_s("prec_pass", 4'b0100);
    flags_c("prec_pass_c", 4'b0100);

    // Extra write after PASS, then restart
    wr(8'h20, 8'h55);
    flags_s("extra_fail", 4'b0010);
    chk("extra_err", 32'(s_err), 1);
    chk("extra_eadr", 32'(s_eadr), 'h20);
    chk("extra_edata", 32'(s_edata), 'h55);
    chk("extra_match", 32'(s_match), 1);
    go(3'd1);
    flags_s("restart_busy", 4'b1000);
    chk("restart_match", 32'(s_match), 0);
    chk("restart_err", 32'(s_err), 0);
    chk("restart_eadr", 32'(s_eadr), 0);
    load(2'd0, 8'hAA, 8'hBB);
    wr(8'h10, 8'h01);
    flags_s("restart_table_kept", 4'b0100);

    // num_exp of 0 behaves as 1
    go(3'd0);
    wr(8'h10, 8'h01);
    flags_s("num0_pass", 4'b0100);

    // Reset mid-run
    go(3'd2);
    wr(8'h10, 8'h01);
    chk("rmid_match", 32'(s_match), 1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    flags_s("rmid_flags", 4'b0000);
    chk("rmid_match0", 32'(s_match), 0);
    chk("rmid_err0", 32'(c_err), 0);
    load(2'd0, 8'h30, 8'h03);
    load(2'd1, 8'h31, 8'h13);
    go(3'd2);
    wr(8'h30, 8'h03);
    wr(8'h31, 8'h13);
    flags_s("rmid_pass", 4'b0100);
    chk("rmid_match2", 32'(s_match), 2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_write_checker.md
# mem_write_checker

Synthesizable, parametrised self-check monitor for the mips_mem memory write bus. It replaces a single hard-wired "address FF must receive 0D" testbench check with a loadable table of up to DEPTH expected writes, checked in order. It also provides match/error counters, first-mismatch capture, a cycle watchdog and a sticky pass/fail/timeout verdict. It sits beside mips_mem in simulation tops and on FPGA builds, where its status outputs drive LEDs.

## Interface
- WIDTH, 8: address and data width of the monitored bus.
- DEPTH, 4: number of expected-write table entries.
- IDXBITS, 2: table index width; DEPTH ≤ 2^IDXBITS.
- CNTBITS, 16: width of the watchdog and event counters.
- TIMEOUT, 3000: number of cycles after start before a timeout verdict.
- STOP_ON_ERR, 1: 1 = first mismatch is terminal; 0 = keep checking and report at the end.

- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset; 0 = in reset.
- exp_we  in  1  write strobe for the expected-write table.
- exp_idx  in  IDXBITS  table entry to write.
- exp_adr  in  WIDTH  expected address for that entry.
- exp_data  in  WIDTH  expected data for that entry.
- num_exp  in  IDXBITS+1  number of entries to check (1..DEPTH); sampled at start.
- start  in  1  one-cycle pulse that arms the checker.
- memwrite  in  1  bus write enable from mips_mem.
- adr  in  WIDTH  bus address.
- writedata  in  WIDTH  bus write data.
- busy  out  1  checker is in RUN.
- pass  out  1  sticky pass verdict.
- fail  out  1  sticky fail verdict.
- timeout  out  1  sticky timeout verdict.
- match_cnt  out  CNTBITS  number of matching writes.
- err_cnt  out  CNTBITS  number of mismatching or extra writes.
- err_adr  out  WIDTH  address of the first mismatch.
- err_data  out  WIDTH  data of the first mismatch.

## Operation
- States: IDLE, RUN, PASS, FAIL, TOUT. Exactly one of busy/pass/fail/timeout is asserted outside IDLE; all four are 0 in IDLE.
- Table loading:
  - exp_we writes entry[exp_idx] in IDLE, PASS, FAIL and TOUT.
  - exp_we is ignored in RUN.
  - exp_idx ≥ DEPTH is ignored.
- start, from any state, including RUN (restart):
  - ptr=0, cyc=0, both counters 0, err_adr/err_data 0, first-error flag cleared.
  - num_exp is latched; a latched value of 0 is treated as 1.
  - Next state is RUN.
- RUN, each cycle with memwrite=1:
  - Compare adr/writedata with entry[ptr].
  - Match: match_cnt+1, ptr+1.
  - Mismatch: err_cnt+1. If this is the first error, capture adr/writedata into err_adr/err_data.
  - STOP_ON_ERR=1: a mismatch goes to FAIL.
  - STOP_ON_ERR=0: ptr+1 on a mismatch as well.
- RUN completion: when ptr reaches the latched num_exp, go to PASS if err_cnt=0, otherwise FAIL.
- Watchdog:
  - cyc increments every RUN cycle.
  - When cyc reaches TIMEOUT-1 with the table incomplete, go to TOUT.
- Same-cycle precedence in RUN, highest first: write completion, then mismatch (STOP_ON_ERR=1), then timeout. A final write that lands on the timeout cycle yields PASS or FAIL, not TOUT.
- PASS: any memwrite is an extra write; err_cnt+1, capture it as the first error, go to FAIL.
- FAIL and TOUT: terminal until start or reset. memwrite is ignored and counters freeze.
- Counters saturate at 2^CNTBITS-1.
- Reset (reset=0 at a rising edge):
  - State IDLE; all outputs 0.
  - Table entries, ptr, cyc and the latched num_exp all 0.
  - Reset in the middle of RUN aborts the run with no verdict.
  - Reset has priority over start.

## Timing
- Inputs are sampled on the rising edge; all outputs are registered.
- A write sampled at edge N updates the counters and verdict visible after edge N, i.e. one cycle of latency.
- start at edge N: busy=1 after edge N. A memwrite at edge N is not checked; the first write checked is at edge N+1.
- Timeout: with no writes and start at edge N, timeout=1 after edge N+TIMEOUT.
- Back-to-back memwrite cycles are each checked; no gap cycle is required.
- A table write at edge N is usable by a start at edge N+1.

## Test plan
- Fibonacci baseline:
  - Stimulus: entry0=(FF,0D), num_exp=1, start; write FF/0D 40 cycles later.
  - Required response: pass=1 one cycle later, match_cnt=1, err_cnt=0.
- Single mismatch, STOP_ON_ERR=1:
  - Stimulus: entry0=(FF,0D); write FF/0C.
  - Required response: fail=1, err_cnt=1, err_adr=FF, err_data=0C; later writes do not change the counters.
- Ordered multi-entry, STOP_ON_ERR=0, DEPTH=4:
  - Stimulus: entries (10,01)(11,01)(12,02)(13,03); writes 10/01, 11/07, 12/02, 13/03 back-to-back.
  - Required response: fail=1 after the fourth write, match_cnt=3, err_cnt=1, err_adr=11, err_data=07.
- Timeout and precedence:
  - Stimulus A: TIMEOUT=300, no writes.
  - Required response A: timeout=1 exactly 300 cycles after start.
  - Stimulus B: the final matching write lands on cycle 299.
  - Required response B: pass=1, timeout=0.
- Extra write and restart:
  - Stimulus: after PASS, write 20/55; then start.
  - Required response: after the extra write, fail=1, err_cnt=1, err_adr=20. After start: counters 0, busy=1, table retained.
- Reset mid-run:
  - Stimulus: reset=0 for 1 cycle during RUN after one match.
  - Required response: all outputs 0, state IDLE. A following start with a reloaded table passes normally.
